// File: rtl/lutram_readback_checker.sv
// LUTRAM read-back checker.
// Receive side of a LUTRAM write/read-back test. Each accepted read strobe is
// compared against an internally regenerated address sequence and data
// pattern; results (pass/fail, error count, sticky error mask and first
// failing address) are held for LEDs or a logic analyser.
module lutram_readback_checker #(
    parameter int A_WIDTH = 7,
    parameter int ERR_W   = 8,
    parameter int PATTERN = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               sample_en_i,
    input  logic [A_WIDTH-1:0] addr_i,
    input  logic               spo_i,
    input  logic               dpo_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [2:0]         err_mask_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic               first_err_vld_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [A_WIDTH-1:0] ADDR_LAST = {A_WIDTH{1'b1}};
    localparam logic [ERR_W-1:0]   CNT_MAX   = {ERR_W{1'b1}};

    logic [1:0]         r_state;
    logic [A_WIDTH-1:0] r_exp_addr;
    logic [ERR_W-1:0]   r_err_count;
    logic [2:0]         r_err_mask;
    logic [A_WIDTH-1:0] r_first_err_addr;
    logic               r_first_err_vld;
    logic               r_done;
    logic               r_pass;

    logic               w_exp_d;
    logic               w_accept;
    logic               w_last;
    logic               w_spo_bad;
    logic               w_dpo_bad;
    logic               w_seq_bad;
    logic               w_bad;
    logic [ERR_W-1:0]   w_cnt_next;

    // Expected read data for the current expected address
    always_comb begin
        w_exp_d = 1'b0;
        if (PATTERN == 0) begin
            w_exp_d = r_exp_addr[0];
        end else if (PATTERN == 1) begin
            w_exp_d = ~r_exp_addr[0];
        end else if (PATTERN == 2) begin
            w_exp_d = 1'b0;
        end else begin
            w_exp_d = 1'b1;
        end
    end

    // A start pulse takes priority, so a coincident strobe is never accepted
    assign w_accept   = (r_state == ST_CHECK) && sample_en_i && !start_i;
    assign w_last     = (r_exp_addr == ADDR_LAST);
    assign w_spo_bad  = (spo_i != w_exp_d);
    assign w_dpo_bad  = (dpo_i != w_exp_d);
    assign w_seq_bad  = (addr_i != r_exp_addr);
    assign w_bad      = w_spo_bad | w_dpo_bad | w_seq_bad;
    assign w_cnt_next = (w_bad && (r_err_count != CNT_MAX)) ? (r_err_count + ERR_W'(1))
                                                            : r_err_count;

    // Run-control state: start arms a run from any state, last sample finishes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else if (start_i) begin
            r_state <= ST_CHECK;
        end else if (w_accept && w_last) begin
            r_state <= ST_DONE;
        end
    end

    // Expected address counter; never resyncs to addr_i so a slip keeps flagging
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exp_addr <= '0;
        end else if (start_i) begin
            r_exp_addr <= '0;
        end else if (w_accept) begin
            r_exp_addr <= r_exp_addr + A_WIDTH'(1);
        end
    end

    // Error accumulation: saturating count, sticky mask, first failing address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_count      <= '0;
            r_err_mask       <= '0;
            r_first_err_addr <= '0;
            r_first_err_vld  <= 1'b0;
        end else if (start_i) begin
            r_err_count      <= '0;
            r_err_mask       <= '0;
            r_first_err_addr <= '0;
            r_first_err_vld  <= 1'b0;
        end else if (w_accept) begin
            r_err_count <= w_cnt_next;
            r_err_mask  <= r_err_mask | {w_seq_bad, w_dpo_bad, w_spo_bad};
            if (w_bad && !r_first_err_vld) begin
                r_first_err_addr <= r_exp_addr;
                r_first_err_vld  <= 1'b1;
            end
        end
    end

    // Final verdict, including the last sample's own contribution to the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (start_i) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_accept && w_last) begin
            r_done <= 1'b1;
            r_pass <= (w_cnt_next == '0);
        end
    end

    assign busy_o           = (r_state == ST_CHECK);
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign err_count_o      = r_err_count;
    assign err_mask_o       = r_err_mask;
    assign first_err_addr_o = r_first_err_addr;
    assign first_err_vld_o  = r_first_err_vld;

endmodule
